// File: rtl/resize_result_writer.sv
// rtl/resize_result_writer.sv - buffers interpolated pixels and writes them to the result RAM in raster order
// A small FIFO absorbs result-RAM stalls; the write address is the count of completed writes.
module resize_result_writer #(
  parameter int OUT_W  = 17,
  parameter int OUT_H  = 17,
  parameter int AW     = 10,
  parameter int FDEPTH = 4
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          START,
  input  logic          I_VALID,
  input  logic [7:0]    I_DATA,
  input  logic          W_READY,
  output logic          WEN,
  output logic [AW-1:0] W_ADDR,
  output logic [7:0]    W_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVF
);

  localparam int PW = $clog2(FDEPTH);
  localparam logic [AW:0]   TOTAL    = (AW+1)'(OUT_W * OUT_H);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [PW:0]   OCC_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   OCC_FULL = (PW+1)'(FDEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_mem [FDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_occ;
  logic [AW:0]   r_in_cnt;
  logic [AW:0]   r_wr_cnt;
  logic          r_ovf;

  logic          w_active;
  logic          w_wen;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_in_nxt;
  logic [AW:0]   w_wr_nxt;

  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_wen    = w_active && (r_occ != '0);
  assign w_pop    = w_wen && W_READY;
  assign w_full   = (r_occ == OCC_FULL);
  // A full FIFO still accepts a pixel when the head leaves on the same edge.
  assign w_push   = (r_state == S_RUN) && I_VALID && !START && (!w_full || w_pop);
  assign w_drop   = I_VALID && !START &&
                    (((r_state == S_RUN) && w_full && !w_pop) || (r_state == S_DRAIN));
  assign w_in_nxt = r_in_cnt + (w_push ? CNT_ONE : '0);
  assign w_wr_nxt = r_wr_cnt + (w_pop ? CNT_ONE : '0);

  always_ff @(posedge clk) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (START) begin
      w_next = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_in_nxt == TOTAL) w_next = (w_wr_nxt == TOTAL) ? S_DONE : S_DRAIN;
        end
        S_DRAIN: begin
          if (w_wr_nxt == TOTAL) w_next = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= I_DATA;
  end

  always_ff @(posedge clk) begin
    if (RST || START) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      r_in_cnt <= '0;
      r_wr_cnt <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_occ <= r_occ + OCC_ONE;
      else if (w_pop && !w_push) r_occ <= r_occ - OCC_ONE;
      r_in_cnt <= w_in_nxt;
      r_wr_cnt <= w_wr_nxt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign WEN    = w_wen;
  assign W_ADDR = r_wr_cnt[AW-1:0];
  assign W_DATA = w_wen ? r_mem[r_rd_ptr] : 8'h00;
  assign BUSY   = w_active;
  assign DONE   = (r_state == S_DONE);
  assign OVF    = r_ovf;

endmodule

// File: tb/tb_resize_result_writer.sv
// tb/tb_resize_result_writer.sv - self-checking bench for resize_result_writer
// A 2x2 instance runs the table and stall/reset sequences; a 3x3 instance covers full-FIFO cases in RUN.
module tb_resize_result_writer;

  logic       clk = 1'b0;
  logic       RST;
  logic       START, I_VALID, W_READY;
  logic [7:0] I_DATA;
  logic       WEN, BUSY, DONE, OVF;
  logic [3:0] W_ADDR;
  logic [7:0] W_DATA;

  logic       b_start, b_valid, b_ready;
  logic [7:0] b_data;
  logic       b_wen, b_busy, b_done, b_ovf;
  logic [3:0] b_addr;
  logic [7:0] b_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int n_bwr = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic       st;
    logic       iv;
    logic [7:0] d;
    logic       acc;
    logic       wen;
    logic [3:0] a;
    logic [7:0] wd;
    logic       busy;
    logic       done;
    logic       ovf;
  } vec_t;

  wr_t  q[$];
  wr_t  qb[$];
  wr_t  e_m, e_b;
  vec_t vecs[$];
  vec_t r;
  logic [3:0] exp_wa;

  always #5 clk = ~clk;

  resize_result_writer #(.OUT_W(2), .OUT_H(2), .AW(4), .FDEPTH(4)) u_dut (
    .clk(clk), .RST(RST), .START(START), .I_VALID(I_VALID), .I_DATA(I_DATA),
    .W_READY(W_READY), .WEN(WEN), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
  );

  resize_result_writer #(.OUT_W(3), .OUT_H(3), .AW(4), .FDEPTH(4)) u_big (
    .clk(clk), .RST(RST), .START(b_start), .I_VALID(b_valid), .I_DATA(b_data),
    .W_READY(b_ready), .WEN(b_wen), .W_ADDR(b_addr), .W_DATA(b_wdata),
    .BUSY(b_busy), .DONE(b_done), .OVF(b_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (WEN && W_READY) begin
      n_wr++;
      if (q.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        e_m = q.pop_front();
        chk("wr_addr", W_ADDR, e_m.a);
        chk("wr_data", W_DATA, e_m.d);
      end
    end
  end

  always @(negedge clk) begin
    if (b_wen && b_ready) begin
      n_bwr++;
      if (qb.size() == 0) begin
        chk("bwr_unexpected", 1, 0);
      end else begin
        e_b = qb.pop_front();
        chk("bwr_addr", b_addr, e_b.a);
        chk("bwr_data", b_wdata, e_b.d);
      end
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic iv, input logic [7:0] d, input logic wr);
    @(posedge clk);
    #1;
    RST = rst; START = st; I_VALID = iv; I_DATA = d; W_READY = wr;
    @(negedge clk);
  endtask

  task automatic cycb(input logic st, input logic iv, input logic [7:0] d, input logic wr);
    @(posedge clk);
    #1;
    b_start = st; b_valid = iv; b_data = d; b_ready = wr;
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 20 && !DONE; k++) cyc(0, 0, 0, 8'd0, 1);
    chk(nm, DONE, 1);
  endtask

  function automatic vec_t mk(logic st, logic iv, logic [7:0] d, logic acc, logic wen,
                              logic [3:0] a, logic [7:0] wd, logic busy, logic done, logic ovf);
    vec_t v;
    v.st = st; v.iv = iv; v.d = d; v.acc = acc; v.wen = wen;
    v.a = a; v.wd = wd; v.busy = busy; v.done = done; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RST = 1; START = 0; I_VALID = 0; I_DATA = 0; W_READY = 0;
    b_start = 0; b_valid = 0; b_data = 0; b_ready = 0;
    exp_wa = 0;

    //          st iv d    acc wen a  wd  busy done ovf
    vecs.push_back(mk(0, 1, 9,   0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 10,  1, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 1, 20,  1, 1, 0, 10, 1, 0, 0));
    vecs.push_back(mk(0, 1, 30,  1, 1, 1, 20, 1, 0, 0));
    vecs.push_back(mk(0, 1, 40,  1, 1, 2, 30, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 1, 3, 40, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 4, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 55,  0, 0, 4, 0,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 4, 0,  0, 1, 0));
    vecs.push_back(mk(1, 1, 77,  0, 0, 4, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 1,   1, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 1, 2,   1, 1, 0, 1,  1, 0, 0));
    vecs.push_back(mk(0, 1, 3,   1, 1, 1, 2,  1, 0, 0));
    vecs.push_back(mk(0, 1, 4,   1, 1, 2, 3,  1, 0, 0));
    vecs.push_back(mk(0, 1, 5,   0, 1, 3, 4,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 4, 0,  0, 1, 1));
    vecs.push_back(mk(0, 1, 6,   0, 0, 4, 0,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 4, 0,  0, 1, 1));

    cyc(1, 0, 0, 8'd0, 0);
    cyc(1, 0, 0, 8'd0, 0);
    chk("rst_wen", WEN, 0);
    chk("rst_addr", W_ADDR, 0);
    chk("rst_data", W_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ovf", OVF, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      cyc(0, r.st, r.iv, r.d, 1);
      if (r.st) exp_wa = 0;
      if (r.acc) begin
        q.push_back({exp_wa, r.d});
        exp_wa = exp_wa + 4'd1;
      end
      chk($sformatf("t%0d_wen", i), WEN, r.wen);
      chk($sformatf("t%0d_addr", i), W_ADDR, r.a);
      if (r.wen) chk($sformatf("t%0d_data", i), W_DATA, r.wd);
      chk($sformatf("t%0d_busy", i), BUSY, r.busy);
      chk($sformatf("t%0d_done", i), DONE, r.done);
      chk($sformatf("t%0d_ovf", i), OVF, r.ovf);
    end

    // Stalled RAM: four pixels buffered, the rest arrive in DRAIN and are lost.
    cyc(0, 1, 0, 8'd0, 0);
    exp_wa = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 1, 8'(101 + k), 0);
      if (k < 4) begin
        q.push_back({exp_wa, 8'(101 + k)});
        exp_wa = exp_wa + 4'd1;
      end
      if (k >= 1) begin
        chk("stall_wen", WEN, 1);
        chk("stall_addr", W_ADDR, 0);
        chk("stall_data", W_DATA, 101);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 8'd0, 0);
      chk("stall_addr2", W_ADDR, 0);
      chk("stall_data2", W_DATA, 101);
      chk("stall_ovf", OVF, 1);
    end
    wait_done("stall_done");
    chk("stall_ovf_end", OVF, 1);
    chk("stall_busy_end", BUSY, 0);

    // Reset mid-frame with two pixels buffered, then reset beating start.
    cyc(0, 1, 0, 8'd0, 0);
    cyc(0, 0, 1, 8'd201, 0);
    cyc(0, 0, 1, 8'd202, 0);
    chk("pre_rst_wen", WEN, 1);
    cyc(1, 0, 0, 8'd0, 0);
    cyc(0, 0, 0, 8'd0, 0);
    chk("mid_rst_wen", WEN, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_addr", W_ADDR, 0);
    cyc(1, 1, 0, 8'd0, 0);
    cyc(0, 0, 0, 8'd0, 0);
    chk("rst_vs_start_busy", BUSY, 0);
    chk("rst_vs_start_done", DONE, 0);
    cyc(0, 1, 0, 8'd0, 1);
    exp_wa = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 8'(211 + k), 1);
      q.push_back({exp_wa, 8'(211 + k)});
      exp_wa = exp_wa + 4'd1;
    end
    wait_done("rerun_done");
    chk("rerun_ovf", OVF, 0);

    // 3x3 frame: push into a full FIFO with and without a same-cycle pop.
    cycb(1, 0, 8'd0, 0);
    exp_wa = 0;
    for (int k = 1; k <= 4; k++) begin
      cycb(0, 1, 8'(k), 0);
      qb.push_back({exp_wa, 8'(k)});
      exp_wa = exp_wa + 4'd1;
    end
    cycb(0, 1, 8'd5, 1);
    qb.push_back({exp_wa, 8'd5});
    exp_wa = exp_wa + 4'd1;
    chk("full_pop_wen", b_wen, 1);
    chk("full_pop_addr", b_addr, 0);
    chk("full_pop_data", b_wdata, 1);
    chk("full_pop_ovf", b_ovf, 0);
    cycb(0, 1, 8'd6, 0);
    chk("full_drop_addr", b_addr, 1);
    chk("full_drop_data", b_wdata, 2);
    chk("full_drop_ovf0", b_ovf, 0);
    cycb(0, 0, 8'd0, 0);
    chk("full_drop_ovf1", b_ovf, 1);
    chk("full_drop_busy", b_busy, 1);
    for (int k = 7; k <= 10; k++) begin
      cycb(0, 1, 8'(k), 1);
      qb.push_back({exp_wa, 8'(k)});
      exp_wa = exp_wa + 4'd1;
    end
    for (int k = 0; k < 20 && !b_done; k++) cycb(0, 0, 8'd0, 1);
    chk("big_done", b_done, 1);
    chk("big_busy", b_busy, 0);
    chk("big_ovf", b_ovf, 1);
    chk("big_writes", n_bwr, 9);
    chk("big_queue_left", qb.size(), 0);

    chk("total_writes", n_wr, 16);
    chk("queue_left", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
